// File: rtl/pool_frame_feeder.sv
// -----------------------------------------------------------------------------
// pool_frame_feeder
//
// Purpose:
//   Streaming pixel source for the pooling/convolution window engines. Reads one
//   IMG_Width x IMG_Height frame from a single-port feature-map RAM in raster
//   order and presents it as a valid/ready pixel stream. After the frame it
//   appends FLUSH_LEN zero pixels so the engine's line buffer drains its last
//   window rows. The control side uses a Start/Busy/Done handshake.
//
// Ports:
//   CLK        in   clock, rising edge
//   CLR        in   asynchronous active-low reset
//   Start      in   one-cycle start pulse, ignored while a frame is in progress
//   Base_Addr  in   frame start address, latched when Start is accepted
//   Rd_En      out  RAM read strobe
//   Rd_Addr    out  RAM read address (Base_Addr + index, modulo 2^Addrwidth)
//   Rd_Data    in   RAM read data, valid one cycle after Rd_En
//   Ready_IN   in   downstream accepts a pixel this cycle
//   Out        out  pixel to engine
//   Valid_OUT  out  Out holds a valid pixel
//   Busy       out  frame in progress
//   Done       out  one-cycle pulse at frame completion
//   Stall_Cnt  out  (only with FEEDER_STALL_CNT_EN) saturating count of cycles
//                   with Valid_OUT=1, Ready_IN=0 while Busy=1
//
// Configuration macro: FEEDER_STALL_CNT_EN adds the Stall_Cnt port and logic.
// -----------------------------------------------------------------------------
module pool_frame_feeder #(
    parameter int IMG_Width  = 7,
    parameter int IMG_Height = 7,
    parameter int Datawidth  = 16,
    parameter int Addrwidth  = 12,
    parameter int FLUSH_LEN  = IMG_Width * 3 + 4
) (
    input  logic                 CLK,
    input  logic                 CLR,
    input  logic                 Start,
    input  logic [Addrwidth-1:0] Base_Addr,
    output logic                 Rd_En,
    output logic [Addrwidth-1:0] Rd_Addr,
    input  logic [Datawidth-1:0] Rd_Data,
    input  logic                 Ready_IN,
    output logic [Datawidth-1:0] Out,
    output logic                 Valid_OUT,
    output logic                 Busy,
`ifdef FEEDER_STALL_CNT_EN
    output logic                 Done,
    output logic [31:0]          Stall_Cnt
`else
    output logic                 Done
`endif
);

    localparam int NPIX = IMG_Width * IMG_Height;
    localparam int IDXW = $clog2(NPIX + 1);
    localparam int COLW = $clog2(IMG_Width + 1);
    localparam int ROWW = $clog2(IMG_Height + 1);
    localparam int FLW  = $clog2(FLUSH_LEN + 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [Addrwidth-1:0]   base_q, base_d;
    logic [IDXW-1:0]        rd_idx_q, rd_idx_d;
    logic                   rd_en_q, rd_en_d;
    logic [Addrwidth-1:0]   rd_addr_q, rd_addr_d;
    logic                   rd_vld_q;           // Rd_Data is valid this cycle
    logic [Datawidth-1:0]   out_q, out_d;
    logic                   vld_q, vld_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [COLW-1:0]        col_q, col_d;
    logic [ROWW-1:0]        row_q, row_d;
    logic [FLW-1:0]         fl_ld_q, fl_ld_d;   // flush zeros loaded into Out
    logic [FLW-1:0]         fl_xf_q, fl_xf_d;   // flush zeros transferred

    // 2-entry skid FIFO between the RAM return path and the output register
    logic [Datawidth-1:0]   fifo_mem_q [2];
    logic                   wr_ptr_q, rd_ptr_q;
    logic [1:0]             fifo_cnt_q, fifo_cnt_d;
    logic                   fifo_push, fifo_pop;

    logic                   xfer, out_free, frame_xfer, last_xfer, load_flush, room;

`ifdef FEEDER_STALL_CNT_EN
    logic [31:0]            stall_q, stall_d;
`endif

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        rd_idx_d   = rd_idx_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        col_d      = col_q;
        row_d      = row_q;
        fl_ld_d    = fl_ld_q;
        fl_xf_d    = fl_xf_q;
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        out_d      = out_q;

        xfer       = vld_q && Ready_IN;
        out_free   = !vld_q || Ready_IN;
        frame_xfer = xfer && (state_q == S_READ || state_q == S_DRAIN);
        last_xfer  = frame_xfer && (col_q == COLW'(IMG_Width - 1))
                                && (row_q == ROWW'(IMG_Height - 1));
        // The first flush zero may enter Out on the same edge the last frame
        // pixel leaves it, so the stream has no bubble between frame and flush.
        load_flush = (FLUSH_LEN > 0) &&
                     ((state_q == S_DRAIN && last_xfer) ||
                      (state_q == S_FLUSH && fl_ld_q < FLW'(FLUSH_LEN)));

        // Output register refill: FIFO head first, then the RAM return, then
        // flush zeros. RAM data not taken directly is always pushed.
        vld_d = vld_q && !Ready_IN;
        if (out_free) begin
            if (fifo_cnt_q != 2'd0) begin
                out_d     = fifo_mem_q[rd_ptr_q];
                vld_d     = 1'b1;
                fifo_pop  = 1'b1;
                fifo_push = rd_vld_q;
            end else if (rd_vld_q) begin
                out_d = Rd_Data;
                vld_d = 1'b1;
            end else if (load_flush) begin
                out_d   = '0;
                vld_d   = 1'b1;
                fl_ld_d = fl_ld_q + 1'b1;
            end
        end else begin
            fifo_push = rd_vld_q;
        end
        fifo_cnt_d = fifo_cnt_q + 2'(fifo_push) - 2'(fifo_pop);

        // A new read is allowed only if everything held or already requested,
        // plus this read, fits in FIFO (2) + output register (1).
        room = ({1'b0, fifo_cnt_d} + 3'(vld_d) + 3'(rd_en_q)) <= 3'd2;

        if (frame_xfer) begin
            if (col_q == COLW'(IMG_Width - 1)) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    base_d    = Base_Addr;
                    busy_d    = 1'b1;
                    rd_en_d   = 1'b1;
                    rd_addr_d = Base_Addr;
                    rd_idx_d  = IDXW'(1);
                    col_d     = '0;
                    row_d     = '0;
                    fl_ld_d   = '0;
                    fl_xf_d   = '0;
                    state_d   = (NPIX == 1) ? S_DRAIN : S_READ;
                end
            end
            S_READ: begin
                if (room) begin
                    rd_en_d   = 1'b1;
                    rd_addr_d = base_q + Addrwidth'(rd_idx_q);
                    rd_idx_d  = rd_idx_q + 1'b1;
                    if (rd_idx_q == IDXW'(NPIX - 1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (last_xfer) begin
                    if (FLUSH_LEN > 0) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                if (xfer) begin
                    fl_xf_d = fl_xf_q + 1'b1;
                    if (fl_xf_q == FLW'(FLUSH_LEN - 1)) begin
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

`ifdef FEEDER_STALL_CNT_EN
    always_comb begin
        stall_d = stall_q;
        if (state_q == S_IDLE && Start) begin
            stall_d = '0;
        end else if (busy_q && vld_q && !Ready_IN && stall_q != 32'hFFFF_FFFF) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign Stall_Cnt = stall_q;
`endif

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            rd_idx_q   <= '0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            rd_vld_q   <= 1'b0;
            out_q      <= '0;
            vld_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            fl_ld_q    <= '0;
            fl_xf_q    <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fifo_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            rd_idx_q   <= rd_idx_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            rd_vld_q   <= rd_en_q;
            out_q      <= out_d;
            vld_q      <= vld_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            col_q      <= col_d;
            row_q      <= row_d;
            fl_ld_q    <= fl_ld_d;
            fl_xf_q    <= fl_xf_d;
            fifo_cnt_q <= fifo_cnt_d;
            if (fifo_push) wr_ptr_q <= ~wr_ptr_q;
            if (fifo_pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    // Pixel storage needs no reset; occupancy is tracked by fifo_cnt_q.
    always_ff @(posedge CLK) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q] <= Rd_Data;
        end
    end

    assign Rd_En     = rd_en_q;
    assign Rd_Addr   = rd_addr_q;
    assign Out       = out_q;
    assign Valid_OUT = vld_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_pool_frame_feeder.sv
module tb_pool_frame_feeder;

    localparam int W     = 7;
    localparam int H     = 7;
    localparam int NPIX  = W * H;
    localparam int FLUSH = W * 3 + 4;
    localparam int TOTAL = NPIX + FLUSH;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [11:0] base_addr;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [15:0] rd_data;
    logic        ready;
    logic [15:0] out_px;
    logic        valid;
    logic        busy;
    logic        done;
`ifdef FEEDER_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    pool_frame_feeder dut (
        .CLK       (clk),
        .CLR       (rst_n),
        .Start     (start),
        .Base_Addr (base_addr),
        .Rd_En     (rd_en),
        .Rd_Addr   (rd_addr),
        .Rd_Data   (rd_data),
        .Ready_IN  (ready),
        .Out       (out_px),
        .Valid_OUT (valid),
        .Busy      (busy),
`ifdef FEEDER_STALL_CNT_EN
        .Done      (done),
        .Stall_Cnt (stall_cnt)
`else
        .Done      (done)
`endif
    );

    always #5 clk = ~clk;

    // RAM model: RAM[a] = a, one-cycle read latency, garbage when not read.
    always @(posedge clk) begin
        rd_data <= rd_en ? {4'h0, rd_addr} : 16'hDEAD;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard
    logic [11:0] exp_addr [$];
    logic [15:0] exp_pix  [$];
    bit          en_mon    = 1'b0;
    bit          done_pend = 1'b0;
    bit          held_vld  = 1'b0;
    logic [15:0] held_out  = '0;
    int          n_rd      = 0;
    int          n_xf      = 0;
    int          n_done    = 0;
    logic [11:0] last_addr = '0;

    task automatic push_frame(input logic [11:0] base);
        logic [11:0] a;
        for (int i = 0; i < NPIX; i++) begin
            a = base + 12'(i);
            exp_addr.push_back(a);
            exp_pix.push_back({4'h0, a});
        end
        for (int i = 0; i < FLUSH; i++) exp_pix.push_back(16'h0000);
    endtask

    always @(negedge clk) begin
        if (en_mon) begin
            chk("done_timing", {31'b0, done}, {31'b0, done_pend});
            done_pend = 1'b0;
            if (held_vld) begin
                chk("hold_valid", {31'b0, valid}, 32'd1);
                chk("hold_out", {16'b0, out_px}, {16'b0, held_out});
            end
            held_vld = valid && !ready;
            held_out = out_px;
            if (rd_en) begin
                n_rd++;
                if (exp_addr.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL rd_extra: got read at 0x%0h, expected no read", rd_addr);
                end else begin
                    chk("rd_addr", {20'b0, rd_addr}, {20'b0, exp_addr.pop_front()});
                end
                chk("outstanding_le3", {31'b0, (n_rd - n_xf) <= 3}, 32'd1);
                last_addr = rd_addr;
            end
            if (valid && ready) begin
                n_xf++;
                if (exp_pix.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL px_extra: got pixel 0x%0h, expected no transfer", out_px);
                end else begin
                    chk("pixel", {16'b0, out_px}, {16'b0, exp_pix.pop_front()});
                    if (exp_pix.size() == 0) done_pend = 1'b1;
                end
            end
            if (done) n_done++;
        end
    end

    function automatic logic rdy(input int mode, input int c);
        case (mode)
            1:       return !(c >= 5 && c <= 14);
            2:       return (c % 2) == 0;
            default: return 1'b1;
        endcase
    endfunction

    task automatic run_frame(input logic [11:0] base, input int mode, input int hold,
                             input int restart_at, output int d_done);
        int  d0;
        bit  fin;
        bit  rs;
        d0 = n_done; fin = 0; rs = 0;
        n_rd = 0; n_xf = 0;
        push_frame(base);
        @(posedge clk); #1;
        start = 1'b1; base_addr = base; ready = rdy(mode, 0);
        for (int c = 1; c < 1000; c++) begin
            @(posedge clk); #1;
            start = (c < hold);
            if (restart_at >= 0 && !rs && n_xf >= restart_at) begin
                start = 1'b1; base_addr = 12'h300; rs = 1;
            end
            ready = rdy(mode, c);
            @(negedge clk); #1;
            if (n_done > d0) begin fin = 1; break; end
        end
        if (!fin) begin
            n_chk++; n_fail++;
            $display("FAIL frame_timeout: got no Done, expected Done within 1000 cycles");
        end
        @(posedge clk); #1;
        start = 1'b0; ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        d_done = n_done - d0;
    endtask

    typedef struct {
        logic [11:0] base;
        int          mode;
        int          hold;
        int          restart_at;
        logic [11:0] exp_last;
    } vec_t;

    vec_t vecs [6];
    int   dd;

    initial begin
        vecs[0] = '{12'h010, 0, 1, -1, 12'h040};  // plain frame
        vecs[1] = '{12'h010, 1, 1, -1, 12'h040};  // Ready low cycles 5-14
        vecs[2] = '{12'h010, 2, 1, -1, 12'h040};  // Ready alternating
        vecs[3] = '{12'hFF0, 0, 1, -1, 12'h020};  // address wrap
        vecs[4] = '{12'h010, 0, 3, -1, 12'h040};  // Start held 3 cycles
        vecs[5] = '{12'h050, 0, 1, 20, 12'h080};  // Start re-pulsed at transfer 20

        rst_n = 1'b0; start = 1'b0; ready = 1'b1; base_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rd_en", {31'b0, rd_en}, 32'd0);
        chk("rst_rd_addr", {20'b0, rd_addr}, 32'd0);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_out", {16'b0, out_px}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        en_mon = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].base, vecs[v].mode, vecs[v].hold, vecs[v].restart_at, dd);
            chk("frame_dones", dd, 1);
            chk("frame_reads", n_rd, NPIX);
            chk("frame_xfers", n_xf, TOTAL);
            chk("last_addr", {20'b0, last_addr}, {20'b0, vecs[v].exp_last});
            chk("addr_q_empty", exp_addr.size(), 0);
            chk("pix_q_empty", exp_pix.size(), 0);
            chk("idle_busy", {31'b0, busy}, 32'd0);
`ifdef FEEDER_STALL_CNT_EN
            if (vecs[v].mode == 1) chk("stall_cnt", stall_cnt, 32'd10);
`endif
        end

        // Reset asserted mid-frame right after the 30th transfer
        n_rd = 0; n_xf = 0;
        push_frame(12'h200);
        @(posedge clk); #1;
        start = 1'b1; base_addr = 12'h200; ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk); #1;
            if (n_xf >= 30) break;
        end
        chk("abort_reached_30", n_xf, 30);
        @(posedge clk); #1;
        en_mon = 1'b0;
        rst_n  = 1'b0;
        #1;
        chk("abort_rd_en", {31'b0, rd_en}, 32'd0);
        chk("abort_rd_addr", {20'b0, rd_addr}, 32'd0);
        chk("abort_valid", {31'b0, valid}, 32'd0);
        chk("abort_out", {16'b0, out_px}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, done}, 32'd0);
        end
        exp_addr.delete();
        exp_pix.delete();
        done_pend = 1'b0;
        held_vld  = 1'b0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        en_mon = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        run_frame(12'h010, 0, 1, -1, dd);
        chk("post_abort_dones", dd, 1);
        chk("post_abort_reads", n_rd, NPIX);
        chk("post_abort_xfers", n_xf, TOTAL);
        chk("post_abort_last", {20'b0, last_addr}, 32'h040);
        chk("post_abort_pix_q", exp_pix.size(), 0);

        en_mon = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
